// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions used by the memory stage: access-size encodings,
// writeback source encodings and the memory-access FSM states.
package mem_stage_pkg;

  // funct3 access size / sign encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Writeback result source select
  localparam logic [1:0] RS_ALU  = 2'b00;
  localparam logic [1:0] RS_MEM  = 2'b01;
  localparam logic [1:0] RS_LINK = 2'b10;

  // Data-memory access sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and
// the data memory (slave). A request is held until dmem_ready is seen.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_wstrb,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_wstrb,
    output dmem_ready,
    output dmem_rdata
  );
endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering for the memory stage: alignment check, store lane
// replication and byte enables, and load lane selection with extension.
// Purely combinational.
module load_store_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        aligned,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Steer lanes according to access size; unknown sizes behave as words
  always_comb begin
    aligned   = 1'b1;
    wdata     = store_data;
    wstrb     = 4'b1111;
    load_data = rdata;
    shifted   = rdata >> {addr_lo, 3'b000};
    lane_byte = shifted[7:0];
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B, F3_BU: begin
        aligned   = 1'b1;
        wdata     = {4{store_data[7:0]}};
        wstrb     = 4'b0001 << addr_lo;
        load_data = (funct3 == F3_BU) ? {24'd0, lane_byte}
                                      : {{24{lane_byte[7]}}, lane_byte};
      end
      F3_H, F3_HU: begin
        aligned   = ~addr_lo[0];
        wdata     = {2{store_data[15:0]}};
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = (funct3 == F3_HU) ? {16'd0, lane_half}
                                      : {{16{lane_half[15]}}, lane_half};
      end
      default: begin
        aligned   = (addr_lo == 2'b00);
        wdata     = store_data;
        wstrb     = 4'b1111;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-memory requests for aligned loads and
// stores, stalls the front of the pipe until the memory answers, drops
// misaligned accesses, and registers the MEM/WB slot.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_valid,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_RegWrite,
  input  logic        ex_mem_MemRead,
  input  logic        ex_mem_MemWrite,
  input  logic [1:0]  ex_mem_ResultSrc,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_store_data,
  input  logic [31:0] ex_mem_link_val,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_RegWrite,
  output logic [1:0]  mem_wb_ResultSrc,
  output logic [31:0] mem_wb_alu_result,
  output logic [31:0] mem_wb_mem_data,
  output logic [31:0] mem_wb_link_val
);

  mem_state_e  state_reg, state_next;
  logic        aligned;
  logic        is_mem;
  logic        pending;
  logic        misaligned;
  logic        req;
  logic        complete;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] load_data;

  load_store_align u_align (
    .funct3     (ex_mem_funct3),
    .addr_lo    (ex_mem_alu_result[1:0]),
    .store_data (ex_mem_store_data),
    .rdata      (dmem.dmem_rdata),
    .aligned    (aligned),
    .wdata      (lane_wdata),
    .wstrb      (lane_wstrb),
    .load_data  (load_data)
  );

  assign is_mem     = ex_mem_valid & (ex_mem_MemRead | ex_mem_MemWrite);
  assign pending    = is_mem & aligned;
  assign misaligned = is_mem & ~aligned;

  // Access state register; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Request/complete decode; while rst_n is low nothing is requested
  always_comb begin
    state_next = state_reg;
    req        = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pending) begin
          req = 1'b1;
          if (dmem.dmem_ready) complete = 1'b1;
          else                 state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (dmem.dmem_ready) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (!rst_n) begin
      req      = 1'b0;
      complete = 1'b0;
    end
  end

  // Bus fields come straight from the held EX/MEM slot, so they stay stable
  // for the whole life of a request
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = ex_mem_MemWrite & rst_n;
  assign dmem.dmem_addr  = rst_n ? {ex_mem_alu_result[31:2], 2'b00} : 32'd0;
  assign dmem.dmem_wdata = rst_n ? lane_wdata : 32'd0;
  assign dmem.dmem_wstrb = rst_n ? lane_wstrb : 4'd0;

  assign mem_stall    = req & ~complete;
  assign mem_misalign = misaligned & rst_n;

  // MEM/WB slot: bubble on stalled edges, otherwise capture the EX/MEM slot;
  // load data only updates when a read completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb_rd         <= 5'd0;
      mem_wb_RegWrite   <= 1'b0;
      mem_wb_ResultSrc  <= 2'd0;
      mem_wb_alu_result <= 32'd0;
      mem_wb_mem_data   <= 32'd0;
      mem_wb_link_val   <= 32'd0;
    end else if (mem_stall) begin
      mem_wb_RegWrite <= 1'b0;
    end else begin
      mem_wb_rd         <= ex_mem_rd;
      mem_wb_RegWrite   <= ex_mem_valid & ex_mem_RegWrite & ~misaligned;
      mem_wb_ResultSrc  <= ex_mem_ResultSrc;
      mem_wb_alu_result <= ex_mem_alu_result;
      mem_wb_link_val   <= ex_mem_link_val;
      if (complete & ex_mem_MemRead) mem_wb_mem_data <= load_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected MEM/WB slots,
// one task per scenario, inline comparisons.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_mem_valid;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_RegWrite;
  logic        ex_mem_MemRead;
  logic        ex_mem_MemWrite;
  logic [1:0]  ex_mem_ResultSrc;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_store_data;
  logic [31:0] ex_mem_link_val;
  logic        mem_stall;
  logic        mem_misalign;
  logic [4:0]  mem_wb_rd;
  logic        mem_wb_RegWrite;
  logic [1:0]  mem_wb_ResultSrc;
  logic [31:0] mem_wb_alu_result;
  logic [31:0] mem_wb_mem_data;
  logic [31:0] mem_wb_link_val;

  mem_stage_if dmem_bus ();

  mem_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_RegWrite   (ex_mem_RegWrite),
    .ex_mem_MemRead    (ex_mem_MemRead),
    .ex_mem_MemWrite   (ex_mem_MemWrite),
    .ex_mem_ResultSrc  (ex_mem_ResultSrc),
    .ex_mem_funct3     (ex_mem_funct3),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_link_val   (ex_mem_link_val),
    .dmem              (dmem_bus),
    .mem_stall         (mem_stall),
    .mem_misalign      (mem_misalign),
    .mem_wb_rd         (mem_wb_rd),
    .mem_wb_RegWrite   (mem_wb_RegWrite),
    .mem_wb_ResultSrc  (mem_wb_ResultSrc),
    .mem_wb_alu_result (mem_wb_alu_result),
    .mem_wb_mem_data   (mem_wb_mem_data),
    .mem_wb_link_val   (mem_wb_link_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        regw;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [31:0] link;
    logic        chk_mdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference load extraction, written independently as shift arithmetic
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] word);
    logic [31:0] s;
    s = word >> (8 * lo);
    if (f3 == F3_B)  return 32'($signed({s[7:0], 24'd0}) >>> 24);
    if (f3 == F3_BU) return {24'd0, s[7:0]};
    if (f3 == F3_H)  return 32'($signed({s[15:0], 16'd0}) >>> 16);
    if (f3 == F3_HU) return {16'd0, s[15:0]};
    return word;
  endfunction

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] link);
    ex_mem_valid      = v;
    ex_mem_rd         = rd;
    ex_mem_RegWrite   = rw;
    ex_mem_MemRead    = mr;
    ex_mem_MemWrite   = mw;
    ex_mem_ResultSrc  = rs;
    ex_mem_funct3     = f3;
    ex_mem_alu_result = addr;
    ex_mem_store_data = sd;
    ex_mem_link_val   = link;
  endtask

  task automatic idle_bus();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RS_ALU, F3_W, 32'd0, 32'd0, 32'd0);
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_bus();
    // a pending load during reset must not leak onto the bus
    drive(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, RS_MEM, F3_W, 32'h100, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (dmem_bus.dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", dmem_bus.dmem_req); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
    total++; if (mem_misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign: got %b want 0", mem_misalign); end
    total++; if ({mem_wb_rd, mem_wb_RegWrite, mem_wb_ResultSrc} !== 8'd0) begin bad++; $display("FAIL rst_wb_ctl: got %h want 00", {mem_wb_rd, mem_wb_RegWrite, mem_wb_ResultSrc}); end
    total++; if ({mem_wb_alu_result, mem_wb_mem_data, mem_wb_link_val} !== 96'd0) begin bad++; $display("FAIL rst_wb_data: got %h want 0", {mem_wb_alu_result, mem_wb_mem_data, mem_wb_link_val}); end
    @(negedge clk);
    idle_bus();
    rst_n = 1'b1;
    $display("reset: checked outputs held at zero");
  endtask

  task automatic test_lw_zero_wait();
    exp_t e;
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, RS_MEM, F3_W, 32'h100, 32'd0, 32'h44);
    dmem_bus.dmem_ready = 1'b1;
    dmem_bus.dmem_rdata = 32'hDEADBEEF;
    exp_q.push_back('{5'd5, 1'b1, 32'h100, 32'hDEADBEEF, 32'h44, 1'b1});
    #1;
    total++; if (dmem_bus.dmem_req !== 1'b1) begin bad++; $display("FAIL lw_req: got %b want 1", dmem_bus.dmem_req); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL lw_stall: got %b want 0", mem_stall); end
    total++; if (dmem_bus.dmem_addr !== 32'h100 || dmem_bus.dmem_we !== 1'b0) begin bad++; $display("FAIL lw_bus: got addr=%h we=%b want 100/0", dmem_bus.dmem_addr, dmem_bus.dmem_we); end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++; if (mem_wb_mem_data !== e.mdata) begin bad++; $display("FAIL lw_data: got %h want %h", mem_wb_mem_data, e.mdata); end
    total++; if (mem_wb_RegWrite !== e.regw || mem_wb_rd !== e.rd) begin bad++; $display("FAIL lw_wb: got rw=%b rd=%0d want %b/%0d", mem_wb_RegWrite, mem_wb_rd, e.regw, e.rd); end
    $display("lw zero-wait: addr=00000100 data=%h", mem_wb_mem_data);
    idle_bus();
  endtask

  task automatic test_load_wait(input logic [2:0] f3, input int waits);
    exp_t e;
    int   stalls;
    stalls = 0;
    @(negedge clk);
    drive(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, RS_MEM, f3, 32'h103, 32'd0, 32'd0);
    dmem_bus.dmem_ready = 1'b0;
    exp_q.push_back('{5'd9, 1'b1, 32'h103, ref_load(f3, 2'b11, 32'h80FF_0000), 32'd0, 1'b1});
    for (int i = 0; i < waits; i++) begin
      #1;
      if (mem_stall === 1'b1) stalls++;
      total++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_addr !== 32'h100) begin bad++; $display("FAIL ldw_hold: got req=%b addr=%h want 1/00000100", dmem_bus.dmem_req, dmem_bus.dmem_addr); end
      @(posedge clk); #1;
      total++; if (mem_wb_RegWrite !== 1'b0) begin bad++; $display("FAIL ldw_bubble: got rw=%b want 0", mem_wb_RegWrite); end
      @(negedge clk);
    end
    dmem_bus.dmem_ready = 1'b1;
    dmem_bus.dmem_rdata = 32'h80FF_0000;
    #1;
    total++; if (stalls !== waits || mem_stall !== 1'b0) begin bad++; $display("FAIL ldw_stalls: got %0d (now %b) want %0d (now 0)", stalls, mem_stall, waits); end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++; if (mem_wb_mem_data !== e.mdata || mem_wb_RegWrite !== 1'b1) begin bad++; $display("FAIL ldw_data: got %h rw=%b want %h rw=1", mem_wb_mem_data, mem_wb_RegWrite, e.mdata); end
    $display("load f3=%b addr=00000103 waits=%0d data=%h", f3, waits, mem_wb_mem_data);
    idle_bus();
  endtask

  task automatic test_stores();
    logic [2:0]  f3_t[3]    = '{F3_H, F3_B, F3_W};
    logic [31:0] addr_t[3]  = '{32'h202, 32'h201, 32'h204};
    logic [31:0] data_t[3]  = '{32'h1234ABCD, 32'h000000CD, 32'hCAFEF00D};
    logic [3:0]  strb_t[3]  = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wdat_t[3]  = '{32'hABCDABCD, 32'hCDCDCDCD, 32'hCAFEF00D};
    int          waits_t[3] = '{0, 0, 1};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, RS_ALU, f3_t[i], addr_t[i], data_t[i], 32'd0);
      exp_q.push_back('{5'd0, 1'b0, addr_t[i], 32'd0, 32'd0, 1'b0});
      for (int w = 0; w < waits_t[i]; w++) begin
        #1;
        total++; if (mem_stall !== 1'b1 || dmem_bus.dmem_wstrb !== strb_t[i]) begin bad++; $display("FAIL st_wait: got stall=%b strb=%b want 1/%b", mem_stall, dmem_bus.dmem_wstrb, strb_t[i]); end
        @(negedge clk);
      end
      dmem_bus.dmem_ready = 1'b1;
      #1;
      total++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_we !== 1'b1 || mem_stall !== 1'b0) begin bad++; $display("FAIL st_req: got req=%b we=%b stall=%b want 1/1/0", dmem_bus.dmem_req, dmem_bus.dmem_we, mem_stall); end
      total++; if (dmem_bus.dmem_wstrb !== strb_t[i]) begin bad++; $display("FAIL st_strb: got %b want %b", dmem_bus.dmem_wstrb, strb_t[i]); end
      total++; if (dmem_bus.dmem_wdata !== wdat_t[i]) begin bad++; $display("FAIL st_wdata: got %h want %h", dmem_bus.dmem_wdata, wdat_t[i]); end
      total++; if (dmem_bus.dmem_addr !== {addr_t[i][31:2], 2'b00}) begin bad++; $display("FAIL st_addr: got %h want %h", dmem_bus.dmem_addr, {addr_t[i][31:2], 2'b00}); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++; if (mem_wb_RegWrite !== e.regw || mem_wb_alu_result !== e.alu) begin bad++; $display("FAIL st_wb: got rw=%b alu=%h want %b/%h", mem_wb_RegWrite, mem_wb_alu_result, e.regw, e.alu); end
      $display("store f3=%b addr=%h strb=%b wdata=%h", f3_t[i], addr_t[i], strb_t[i], wdat_t[i]);
      idle_bus();
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  f3_t[3]   = '{F3_W, F3_H, F3_W};
    logic [31:0] addr_t[3] = '{32'h101, 32'h103, 32'h102};
    logic        rd_t[3]   = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd12, rd_t[i], rd_t[i], ~rd_t[i], RS_MEM, f3_t[i], addr_t[i], 32'h55, 32'd0);
      dmem_bus.dmem_ready = 1'b1;
      #1;
      total++; if (dmem_bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL mis_req: got req=%b stall=%b want 0/0", dmem_bus.dmem_req, mem_stall); end
      total++; if (mem_misalign !== 1'b1) begin bad++; $display("FAIL mis_pulse: got %b want 1", mem_misalign); end
      @(posedge clk); #1;
      total++; if (mem_wb_RegWrite !== 1'b0) begin bad++; $display("FAIL mis_rw: got %b want 0", mem_wb_RegWrite); end
      idle_bus();
      @(negedge clk); #1;
      total++; if (mem_misalign !== 1'b0) begin bad++; $display("FAIL mis_end: got %b want 0", mem_misalign); end
      $display("misaligned f3=%b addr=%h dropped", f3_t[i], addr_t[i]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3_t[6]   = '{F3_W, F3_W, F3_H, F3_HU, F3_B, F3_BU};
    logic [1:0]  rs_t[6]   = '{RS_ALU, RS_LINK, RS_MEM, RS_MEM, RS_MEM, RS_MEM};
    logic [31:0] addr_t[6] = '{32'h55, 32'h77, 32'h402, 32'h400, 32'h401, 32'h402};
    logic [31:0] rdata;
    logic        ld;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ld = (rs_t[i] == RS_MEM);
      rdata = $urandom | 32'h8080_8080;
      drive(1'b1, 5'(i + 1), 1'b1, ld, 1'b0, rs_t[i], f3_t[i], addr_t[i], 32'd0, 32'h1000 + i);
      dmem_bus.dmem_ready = ld;
      dmem_bus.dmem_rdata = rdata;
      exp_q.push_back('{5'(i + 1), 1'b1, addr_t[i], ref_load(f3_t[i], addr_t[i][1:0], rdata),
                       32'h1000 + i, ld});
      #1;
      total++; if (dmem_bus.dmem_req !== ld || mem_stall !== 1'b0) begin bad++; $display("FAIL b2b_req[%0d]: got req=%b stall=%b want %b/0", i, dmem_bus.dmem_req, mem_stall, ld); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++; if (mem_wb_rd !== e.rd || mem_wb_RegWrite !== e.regw || mem_wb_alu_result !== e.alu || mem_wb_link_val !== e.link) begin bad++; $display("FAIL b2b_slot[%0d]: got rd=%0d rw=%b alu=%h link=%h want %0d/%b/%h/%h", i, mem_wb_rd, mem_wb_RegWrite, mem_wb_alu_result, mem_wb_link_val, e.rd, e.regw, e.alu, e.link); end
      if (e.chk_mdata) begin
        total++; if (mem_wb_mem_data !== e.mdata) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, mem_wb_mem_data, e.mdata); end
      end
      $display("b2b op %0d src=%b addr=%h data=%h", i, rs_t[i], addr_t[i], mem_wb_mem_data);
    end
    idle_bus();
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drive(1'b1, 5'd20, 1'b1, 1'b1, 1'b0, RS_MEM, F3_W, 32'h300, 32'd0, 32'h9);
    dmem_bus.dmem_ready = 1'b0;
    @(negedge clk); #1;
    total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL rw_wait: got stall=%b want 1", mem_stall); end
    rst_n = 1'b0;
    #1;
    total++; if (dmem_bus.dmem_req !== 1'b0 || mem_stall !== 1'b0 || dmem_bus.dmem_we !== 1'b0 || dmem_bus.dmem_wstrb !== 4'd0) begin bad++; $display("FAIL rw_bus: got req=%b stall=%b we=%b strb=%b want all 0", dmem_bus.dmem_req, mem_stall, dmem_bus.dmem_we, dmem_bus.dmem_wstrb); end
    total++; if ({mem_wb_alu_result, mem_wb_mem_data, mem_wb_RegWrite} !== 65'd0) begin bad++; $display("FAIL rw_wb: got alu=%h data=%h rw=%b want 0", mem_wb_alu_result, mem_wb_mem_data, mem_wb_RegWrite); end
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    dmem_bus.dmem_ready = 1'b1;
    dmem_bus.dmem_rdata = 32'h1111_1111;
    #1;
    total++; if (dmem_bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin bad++; $display("FAIL rw_idle: got req=%b stall=%b want 0/0", dmem_bus.dmem_req, mem_stall); end
    @(posedge clk); #1;
    total++; if (mem_wb_RegWrite !== 1'b0 || mem_wb_mem_data !== 32'd0) begin bad++; $display("FAIL rw_late: got rw=%b data=%h want 0/00000000", mem_wb_RegWrite, mem_wb_mem_data); end
    $display("reset in wait: late ready ignored");
    idle_bus();
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_load_wait(F3_B, 3);
    test_load_wait(F3_BU, 3);
    test_stores();
    test_misalign();
    test_back_to_back();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
